// File: rtl/fsm_full_if.sv
// Request/grant bundle for the four-agent arbiter; the agent side is the master
// and drives requests, the arbiter side is the slave and drives grants.
interface fsm_full_if;
  logic [3:0] req;
  logic [3:0] gnt;

  modport master (output req, input gnt);
  modport slave  (input req, output gnt);
endinterface

// File: rtl/fsm_full.sv
// Four-agent fixed-priority arbiter without preemption; every grant is followed
// by at least one all-zero IDLE cycle before the next grant.
module fsm_full (
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  input  logic req_2,
  input  logic req_3,
  output logic gnt_0,
  output logic gnt_1,
  output logic gnt_2,
  output logic gnt_3
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2,
    GNT2 = 3'd3,
    GNT3 = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] gnt_q;
  logic [3:0] gnt_d;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves next_state unassigned (no latch).
    next_state = IDLE;
    case (state)
      IDLE: begin
        if      (req_0) next_state = GNT0;
        else if (req_1) next_state = GNT1;
        else if (req_2) next_state = GNT2;
        else if (req_3) next_state = GNT3;
        else            next_state = IDLE;
      end
      GNT0:    next_state = req_0 ? GNT0 : IDLE;
      GNT1:    next_state = req_1 ? GNT1 : IDLE;
      GNT2:    next_state = req_2 ? GNT2 : IDLE;
      GNT3:    next_state = req_3 ? GNT3 : IDLE;
      default: next_state = IDLE;  // unused encodings fall back to IDLE
    endcase
  end

  // Grants are decoded from the next state so the registered grant always
  // matches the registered state on the same edge.
  always_comb begin
    gnt_d = 4'b0000;
    case (next_state)
      GNT0:    gnt_d = 4'b0001;
      GNT1:    gnt_d = 4'b0010;
      GNT2:    gnt_d = 4'b0100;
      GNT3:    gnt_d = 4'b1000;
      default: gnt_d = 4'b0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt_q <= 4'b0000;
    end else begin
      state <= next_state;
      gnt_q <= gnt_d;
    end
  end

  assign gnt_0 = gnt_q[0];
  assign gnt_1 = gnt_q[1];
  assign gnt_2 = gnt_q[2];
  assign gnt_3 = gnt_q[3];

endmodule

// File: tb/tb_fsm_full.sv
// Self-checking bench for fsm_full: a reference model pushes expected grant
// vectors to a scoreboard queue, popped and compared after each rising edge.
module tb_fsm_full;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  logic [3:0] model_gnt;
  logic [3:0] exp_q[$];

  fsm_full_if bus ();

  fsm_full dut (
    .clock (clock),
    .reset (reset),
    .req_0 (bus.req[0]),
    .req_1 (bus.req[1]),
    .req_2 (bus.req[2]),
    .req_3 (bus.req[3]),
    .gnt_0 (bus.gnt[0]),
    .gnt_1 (bus.gnt[1]),
    .gnt_2 (bus.gnt[2]),
    .gnt_3 (bus.gnt[3])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Reference behaviour: grant-vector view of the arbiter.
  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [3:0] req);
    logic [3:0] nxt;
    nxt = 4'b0000;
    if (cur == 4'b0000) begin
      for (int i = 3; i >= 0; i--)
        if (req[i]) nxt = 4'b0001 << i;
    end else if ((cur & req) != 4'b0000) begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // One clock: drive requests on the falling edge, compare just after the rising edge.
  task automatic step(input logic [3:0] req, input string tag);
    logic [3:0] exp;
    @(negedge clock);
    bus.req = req;
    model_gnt = model_next(model_gnt, req);
    exp_q.push_back(model_gnt);
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus.gnt !== exp) begin
      errors++;
      $display("FAIL %s: req=%b gnt=%b expected=%b", tag, req, bus.gnt, exp);
    end
    checks++;
    if (!$onehot0(bus.gnt)) begin
      errors++;
      $display("FAIL %s_onehot: gnt=%b expected at most one bit set", tag, bus.gnt);
    end
  endtask

  task automatic test_reset();
    bus.req   = 4'b0000;
    reset     = 1'b0;
    model_gnt = 4'b0000;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: gnt=%b expected=0000", bus.gnt);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) step(4'b0000, "reset_idle");
  endtask

  task automatic test_single_agent();
    for (int n = 0; n < 4; n++) begin
      repeat (5) step(4'b0001 << n, $sformatf("single%0d_hold", n));
      step(4'b0000, $sformatf("single%0d_release", n));
      step(4'b0000, $sformatf("single%0d_idle", n));
    end
  endtask

  task automatic test_priority();
    step(4'b1110, "prio_grant1");
    step(4'b1110, "prio_hold1");
    step(4'b1100, "prio_gap");
    step(4'b1100, "prio_grant2");
    step(4'b1000, "prio_release2");
    step(4'b1000, "prio_grant3");
    step(4'b0000, "prio_release3");
    step(4'b0000, "prio_idle");
  endtask

  task automatic test_no_preempt();
    step(4'b1000, "nopre_grant3");
    repeat (3) step(4'b1001, "nopre_hold3");
    step(4'b0001, "nopre_gap");
    step(4'b0001, "nopre_grant0");
    step(4'b0000, "nopre_release0");
    step(4'b0000, "nopre_idle");
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    step(4'b0100, "areset_grant2");
    step(4'b0100, "areset_hold2");
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_gnt = 4'b0000;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL areset_drop: gnt=%b expected=0000", bus.gnt);
    end
    #1;
    reset = 1'b1;
    model_gnt = model_next(model_gnt, bus.req);
    exp_q.push_back(model_gnt);
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus.gnt !== exp) begin
      errors++;
      $display("FAIL areset_regrant: gnt=%b expected=%b", bus.gnt, exp);
    end
    step(4'b0000, "areset_release");
    step(4'b0000, "areset_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      step(4'($urandom_range(0, 15)), "random");
    step(4'b0000, "random_drain");
    step(4'b0000, "random_idle");
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    bus.req = 4'b0000;
    reset   = 1'b0;
    test_reset();
    test_single_agent();
    test_priority();
    test_no_preempt();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
